// File: rtl/rtc_pkg.sv
// Shared types, digit limits and time legality check for the BCD real-time clock.
package rtc_pkg;

  typedef logic [3:0]  bcd_digit_t;
  typedef logic [23:0] rtc_time_t;

  localparam bcd_digit_t S0_MAX            = 4'd9;
  localparam bcd_digit_t S1_MAX            = 4'd5;
  localparam bcd_digit_t M0_MAX            = 4'd9;
  localparam bcd_digit_t M1_MAX            = 4'd5;
  localparam bcd_digit_t H0_MAX            = 4'd9;
  localparam bcd_digit_t H1_MAX            = 4'd2;
  localparam bcd_digit_t H_MAX_TENS2_UNITS = 4'd3;

  typedef enum logic [1:0] {
    StStopped,
    StRunning,
    StLoading
  } rtc_state_e;

  // True when every digit of a packed HHMMSS value is in range and hours <= 23.
  function automatic logic time_is_legal(rtc_time_t t);
    logic hours_ok;
    if (t[23:20] < H1_MAX) begin
      hours_ok = (t[19:16] <= H0_MAX);
    end else begin
      hours_ok = (t[23:20] == H1_MAX) && (t[19:16] <= H_MAX_TENS2_UNITS);
    end
    return hours_ok && (t[15:12] <= M1_MAX) && (t[11:8] <= M0_MAX) &&
           (t[7:4] <= S1_MAX) && (t[3:0] <= S0_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit: loadable, wraps to zero past max_i, carry out when wrapping.
module bcd_digit_counter
  import rtc_pkg::*;
#(
  parameter bcd_digit_t ResetVal = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  bcd_digit_t load_val_i,
  input  bcd_digit_t max_i,
  input  logic       carry_i,
  output bcd_digit_t digit_o,
  output logic       carry_o
);

  bcd_digit_t digit_q, digit_d;

  always_comb begin
    carry_o = carry_i && (digit_q == max_i);
    digit_d = digit_q;
    if (load_i) begin
      digit_d = load_val_i;
    end else if (carry_o) begin
      digit_d = '0;
    end else if (carry_i) begin
      digit_d = digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= ResetVal;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o = digit_q;

endmodule

// File: rtl/rtc_bcd_counter.sv
// 24-hour HH:MM:SS BCD time-of-day counter with run/stop and validated load.
// Defining RTC_ALARM_EN adds an HH:MM alarm register and alarm_pulse output.
module rtc_bcd_counter
  import rtc_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 1,
  parameter rtc_time_t   RESET_TIME    = 24'h00_00_00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        run,
  input  logic        load_valid,
  input  logic [23:0] load_time,
`ifdef RTC_ALARM_EN
  input  logic        alarm_wr,
  input  logic [15:0] alarm_time,
  input  logic        alarm_arm,
  output logic        alarm_pulse,
`endif
  output logic        load_ready,
  output logic        load_err,
  output logic [23:0] time_bcd,
  output logic        sec_pulse,
  output logic        min_pulse,
  output logic        hour_pulse,
  output logic        day_pulse
);

  localparam logic [7:0] PrescMax = 8'(TICKS_PER_SEC - 1);

  rtc_state_e state_q, state_d;
  logic [7:0] presc_q, presc_d;
  rtc_time_t  load_q, load_d;
  logic       load_err_q, load_err_d;
  logic       sec_pulse_q, min_pulse_q, hour_pulse_q, day_pulse_q;
  logic       accept, inc_en, sec_inc, load_apply, alarm_err;
  logic       c_s0, c_s1, c_m0, c_m1, c_h0, c_h1;
  bcd_digit_t d_s0, d_s1, d_m0, d_m1, d_h0, d_h1, h0_max;

  always_comb begin
    load_ready = (state_q != StLoading);
    accept     = load_valid && load_ready;
    load_apply = (state_q == StLoading) && time_is_legal(load_q);
    load_err_d = ((state_q == StLoading) && !time_is_legal(load_q)) || alarm_err;
    inc_en     = (state_q == StRunning) && tick && !accept;
    load_d     = accept ? load_time : load_q;

    presc_d = presc_q;
    sec_inc = 1'b0;
    if (accept) begin
      presc_d = '0;
    end else if (inc_en) begin
      if (presc_q == PrescMax) begin
        presc_d = '0;
        sec_inc = 1'b1;
      end else begin
        presc_d = presc_q + 8'd1;
      end
    end

    state_d = state_q;
    unique case (state_q)
      StStopped: if (run) state_d = StRunning;
      StRunning: if (!run) state_d = StStopped;
      StLoading: state_d = run ? StRunning : StStopped;
      default:   state_d = StStopped;
    endcase
    if (accept) state_d = StLoading;
  end

  // Hour units may only reach 3 while hour tens is 2.
  assign h0_max = (d_h1 == H1_MAX) ? H_MAX_TENS2_UNITS : H0_MAX;

  bcd_digit_counter #(.ResetVal(RESET_TIME[3:0])) u_s0 (
    .clk(clk), .rst(rst), .load_i(load_apply), .load_val_i(load_q[3:0]),
    .max_i(S0_MAX), .carry_i(sec_inc), .digit_o(d_s0), .carry_o(c_s0)
  );
  bcd_digit_counter #(.ResetVal(RESET_TIME[7:4])) u_s1 (
    .clk(clk), .rst(rst), .load_i(load_apply), .load_val_i(load_q[7:4]),
    .max_i(S1_MAX), .carry_i(c_s0), .digit_o(d_s1), .carry_o(c_s1)
  );
  bcd_digit_counter #(.ResetVal(RESET_TIME[11:8])) u_m0 (
    .clk(clk), .rst(rst), .load_i(load_apply), .load_val_i(load_q[11:8]),
    .max_i(M0_MAX), .carry_i(c_s1), .digit_o(d_m0), .carry_o(c_m0)
  );
  bcd_digit_counter #(.ResetVal(RESET_TIME[15:12])) u_m1 (
    .clk(clk), .rst(rst), .load_i(load_apply), .load_val_i(load_q[15:12]),
    .max_i(M1_MAX), .carry_i(c_m0), .digit_o(d_m1), .carry_o(c_m1)
  );
  bcd_digit_counter #(.ResetVal(RESET_TIME[19:16])) u_h0 (
    .clk(clk), .rst(rst), .load_i(load_apply), .load_val_i(load_q[19:16]),
    .max_i(h0_max), .carry_i(c_m1), .digit_o(d_h0), .carry_o(c_h0)
  );
  bcd_digit_counter #(.ResetVal(RESET_TIME[23:20])) u_h1 (
    .clk(clk), .rst(rst), .load_i(load_apply), .load_val_i(load_q[23:20]),
    .max_i(H1_MAX), .carry_i(c_h0), .digit_o(d_h1), .carry_o(c_h1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StStopped;
      presc_q      <= '0;
      load_q       <= '0;
      load_err_q   <= 1'b0;
      sec_pulse_q  <= 1'b0;
      min_pulse_q  <= 1'b0;
      hour_pulse_q <= 1'b0;
      day_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      load_q       <= load_d;
      load_err_q   <= load_err_d;
      sec_pulse_q  <= sec_inc;
      min_pulse_q  <= c_s1;
      hour_pulse_q <= c_m1;
      day_pulse_q  <= c_h1;
    end
  end

  assign time_bcd   = {d_h1, d_h0, d_m1, d_m0, d_s1, d_s0};
  assign load_err   = load_err_q;
  assign sec_pulse  = sec_pulse_q;
  assign min_pulse  = min_pulse_q;
  assign hour_pulse = hour_pulse_q;
  assign day_pulse  = day_pulse_q;

`ifdef RTC_ALARM_EN
  logic [15:0] alarm_q, alarm_d;

  always_comb begin
    alarm_d   = alarm_q;
    alarm_err = 1'b0;
    if (alarm_wr) begin
      if (time_is_legal({alarm_time, 8'h00})) begin
        alarm_d = alarm_time;
      end else begin
        alarm_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_q <= '0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  // Only a minute rollover can fire, so loading a matching time never does.
  assign alarm_pulse = alarm_arm && min_pulse_q && (time_bcd[23:8] == alarm_q);
`else
  assign alarm_err = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_bcd_counter.sv
// Scoreboard bench for rtc_bcd_counter: integer-time reference model plus directed scenarios.
module tb_rtc_bcd_counter;

  typedef struct packed {
    logic [23:0] t;
    logic sp, mp, hp, dp, err, rdy, al;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, tick = 1'b0, run = 1'b0, load_valid = 1'b0;
  logic [23:0] load_time = '0;
  logic        load_ready, load_err, sec_pulse, min_pulse, hour_pulse, day_pulse;
  logic [23:0] time_bcd;

  logic        tick4 = 1'b0, run4 = 1'b0, lv4 = 1'b0;
  logic [23:0] lt4 = '0;
  logic        ready4, err4, sec_pulse4, min4, hour4, day4;
  logic [23:0] time4;

`ifdef RTC_ALARM_EN
  logic        alarm_wr = 1'b0, alarm_arm = 1'b0, alarm_pulse;
  logic [15:0] alarm_time = '0;
  logic        aw4 = 1'b0, aa4 = 1'b0, ap4;
  logic [15:0] at4 = '0;
`endif

  rtc_bcd_counter u_dut (
    .clk(clk), .rst(rst), .tick(tick), .run(run), .load_valid(load_valid),
    .load_time(load_time),
`ifdef RTC_ALARM_EN
    .alarm_wr(alarm_wr), .alarm_time(alarm_time), .alarm_arm(alarm_arm),
    .alarm_pulse(alarm_pulse),
`endif
    .load_ready(load_ready), .load_err(load_err), .time_bcd(time_bcd),
    .sec_pulse(sec_pulse), .min_pulse(min_pulse), .hour_pulse(hour_pulse),
    .day_pulse(day_pulse)
  );

  rtc_bcd_counter #(.TICKS_PER_SEC(4)) u_dut4 (
    .clk(clk), .rst(rst), .tick(tick4), .run(run4), .load_valid(lv4), .load_time(lt4),
`ifdef RTC_ALARM_EN
    .alarm_wr(aw4), .alarm_time(at4), .alarm_arm(aa4), .alarm_pulse(ap4),
`endif
    .load_ready(ready4), .load_err(err4), .time_bcd(time4), .sec_pulse(sec_pulse4),
    .min_pulse(min4), .hour_pulse(hour4), .day_pulse(day4)
  );

  int n_checks = 0, n_fail = 0;
  int sec_cnt = 0, min_cnt = 0, min_at = 0, sec4_cnt = 0;
  obs_t exp_q[$];
  obs_t mon_e;

  // Reference model state (dut with one tick per second).
  int m_state = 0, m_pre = 0, m_h = 0, m_m = 0, m_s = 0;
  logic [23:0] m_ld = '0;
  logic [15:0] m_alarm = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic bit legal_time(input logic [23:0] t);
    int h, m, s;
    if (t[19:16] > 9 || t[11:8] > 9 || t[3:0] > 9) return 1'b0;
    h = int'(t[23:20]) * 10 + int'(t[19:16]);
    m = int'(t[15:12]) * 10 + int'(t[11:8]);
    s = int'(t[7:4]) * 10 + int'(t[3:0]);
    return (h < 24) && (m < 60) && (s < 60);
  endfunction

  task automatic model_step(output obs_t e);
    bit accept;
    e = '0;
    if (rst) begin
      m_state = 0; m_pre = 0; m_h = 0; m_m = 0; m_s = 0; m_ld = '0; m_alarm = '0;
    end else begin
      accept = load_valid && (m_state != 2);
      if (m_state == 2) begin
        if (legal_time(m_ld)) begin
          m_h = int'(m_ld[23:20]) * 10 + int'(m_ld[19:16]);
          m_m = int'(m_ld[15:12]) * 10 + int'(m_ld[11:8]);
          m_s = int'(m_ld[7:4]) * 10 + int'(m_ld[3:0]);
        end else begin
          e.err = 1'b1;
        end
      end else if (m_state == 1 && tick && !accept) begin
        m_pre++;
        if (m_pre == 1) begin
          m_pre = 0; m_s++; e.sp = 1'b1;
          if (m_s == 60) begin
            m_s = 0; m_m++; e.mp = 1'b1;
            if (m_m == 60) begin
              m_m = 0; m_h++; e.hp = 1'b1;
              if (m_h == 24) begin m_h = 0; e.dp = 1'b1; end
            end
          end
        end
      end
`ifdef RTC_ALARM_EN
      if (alarm_wr) begin
        if (legal_time({alarm_time, 8'h00})) m_alarm = alarm_time;
        else e.err = 1'b1;
      end
`endif
      if (accept) begin m_ld = load_time; m_pre = 0; end
      m_state = accept ? 2 : (run ? 1 : 0);
    end
    e.t   = to_bcd(m_h, m_m, m_s);
    e.rdy = (m_state != 2);
`ifdef RTC_ALARM_EN
    e.al  = alarm_arm && e.mp && (e.t[23:8] == m_alarm);
`endif
  endtask

  // Inputs change just after a falling edge; expectation for the next rising edge is queued.
  task automatic step();
    obs_t e;
    model_step(e);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [23:0] v);
    load_valid = 1'b1;
    load_time  = v;
    step();
    check("load_ready_low", {31'b0, load_ready}, 32'd0);
    load_valid = 1'b0;
    step();
  endtask

  always @(posedge clk) begin
    #1;
    if (sec_pulse4) sec4_cnt++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("time_bcd", {8'b0, time_bcd}, {8'b0, mon_e.t});
      check("sec_pulse", {31'b0, sec_pulse}, {31'b0, mon_e.sp});
      check("min_pulse", {31'b0, min_pulse}, {31'b0, mon_e.mp});
      check("hour_pulse", {31'b0, hour_pulse}, {31'b0, mon_e.hp});
      check("day_pulse", {31'b0, day_pulse}, {31'b0, mon_e.dp});
      check("load_err", {31'b0, load_err}, {31'b0, mon_e.err});
      check("load_ready", {31'b0, load_ready}, {31'b0, mon_e.rdy});
`ifdef RTC_ALARM_EN
      check("alarm_pulse", {31'b0, alarm_pulse}, {31'b0, mon_e.al});
`endif
      if (sec_pulse) sec_cnt++;
      if (min_pulse) begin min_cnt++; min_at = sec_cnt; end
    end
  end

  initial begin
    @(negedge clk);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_time", {8'b0, time_bcd}, 32'h0);
    check("rst_ready", {31'b0, load_ready}, 32'd1);
    check("rst_time4", {8'b0, time4}, 32'h0);

    // Four ticks per second: a partial second survives a stop.
    run4 = 1'b1;
    step();
    repeat (3) begin tick4 = 1'b1; step(); tick4 = 1'b0; step(); end
    run4 = 1'b0;
    step();
    repeat (5) begin tick4 = 1'b1; step(); tick4 = 1'b0; step(); end
    check("tps4_stopped_time", {8'b0, time4}, 32'h0);
    check("tps4_stopped_secs", sec4_cnt, 0);
    run4 = 1'b1;
    step();
    tick4 = 1'b1; step(); tick4 = 1'b0; step();
    check("tps4_time", {8'b0, time4}, 32'h000001);
    check("tps4_secs", sec4_cnt, 1);

    // Sixty seconds roll one minute.
    sec_cnt = 0; min_cnt = 0; min_at = 0;
    run = 1'b1;
    step();
    repeat (60) begin tick = 1'b1; step(); tick = 1'b0; step(); end
    check("minute_time", {8'b0, time_bcd}, 32'h000100);
    check("minute_count", min_cnt, 1);
    check("minute_on_60th", min_at, 60);

    // Day rollover.
    do_load(24'h235959);
    tick = 1'b1; step(); tick = 1'b0;
    check("day_time", {8'b0, time_bcd}, 32'h0);
    check("day_sec", {31'b0, sec_pulse}, 32'd1);
    check("day_min", {31'b0, min_pulse}, 32'd1);
    check("day_hour", {31'b0, hour_pulse}, 32'd1);
    check("day_day", {31'b0, day_pulse}, 32'd1);
    step();

    // Load validation.
    do_load(24'h246000);
    check("bad_hours_err", {31'b0, load_err}, 32'd1);
    check("bad_hours_time", {8'b0, time_bcd}, 32'h0);
    do_load(24'h125960);
    check("bad_secs_err", {31'b0, load_err}, 32'd1);
    do_load(24'h095959);
    check("good_load_err", {31'b0, load_err}, 32'd0);
    check("good_load_time", {8'b0, time_bcd}, 32'h095959);

    // Load and tick together: tick is lost.
    load_valid = 1'b1; load_time = 24'h120000; tick = 1'b1;
    step();
    check("coll_ready", {31'b0, load_ready}, 32'd0);
    load_valid = 1'b0; tick = 1'b0;
    step();
    step();
    check("coll_time", {8'b0, time_bcd}, 32'h120000);

    // Tick during the loading cycle is dropped.
    load_valid = 1'b1; load_time = 24'h010000;
    step();
    load_valid = 1'b0; tick = 1'b1;
    step();
    tick = 1'b0;
    check("loading_tick_time", {8'b0, time_bcd}, 32'h010000);

    // Reset during the loading cycle discards the load.
    load_valid = 1'b1; load_time = 24'h050505;
    step();
    load_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_load_time", {8'b0, time_bcd}, 32'h0);
    check("rst_mid_load_ready", {31'b0, load_ready}, 32'd1);
    step();

`ifdef RTC_ALARM_EN
    alarm_wr = 1'b1; alarm_time = 16'h0730; alarm_arm = 1'b1;
    step();
    alarm_wr = 1'b0;
    do_load(24'h072959);
    tick = 1'b1; step(); tick = 1'b0;
    check("alarm_fire", {31'b0, alarm_pulse}, 32'd1);
    check("alarm_time", {8'b0, time_bcd}, 32'h073000);
    step();
    check("alarm_one_cycle", {31'b0, alarm_pulse}, 32'd0);
    alarm_arm = 1'b0;
    do_load(24'h072959);
    tick = 1'b1; step(); tick = 1'b0;
    check("alarm_disarmed", {31'b0, alarm_pulse}, 32'd0);
    alarm_wr = 1'b1; alarm_time = 16'h2400;
    step();
    alarm_wr = 1'b0;
    check("alarm_bad_err", {31'b0, load_err}, 32'd1);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) run = ~run;
      load_valid = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 1) == 0) begin
        load_time = to_bcd($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      end else begin
        load_time = 24'($urandom());
      end
      rst = ($urandom_range(0, 149) == 0);
`ifdef RTC_ALARM_EN
      alarm_arm  = ($urandom_range(0, 1) == 0);
      alarm_wr   = ($urandom_range(0, 29) == 0);
      alarm_time = 16'($urandom());
`endif
      step();
    end
    tick = 1'b0; load_valid = 1'b0; rst = 1'b0;
`ifdef RTC_ALARM_EN
    alarm_wr = 1'b0;
`endif
    step();
    step();
    check("sb_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_bcd_counter.md
Name: rtc_bcd_counter

Overview:
- Real-time-of-day counter fed by the one-cycle tick pulse from the board's Hz-rate clock divider. It keeps HH:MM:SS in packed BCD, 24-hour format.
- Supports run/stop and a validated time-load handshake.
- Drives display and LED stages downstream with time digits and per-unit rollover pulses.

Parameters:
- TICKS_PER_SEC, 1: number of tick pulses per counted second. Allows a 2 Hz/4 Hz divider tick to drive the block. Range 1..255.
- RESET_TIME, 24'h00_00_00: BCD HHMMSS value loaded on reset. Must be a legal time.

Ports:
- clk, input, 1: system clock, 12 MHz.
- rst, input, 1: reset, synchronous, active-high.
- tick, input, 1: single-cycle pulse from the divider; sampled only when high for exactly one clk.
- run, input, 1: 1 counts ticks, 0 freezes time.
- load_valid, input, 1: load request.
- load_time, input, 24: BCD {H1,H0,M1,M0,S1,S0}, 4 bits per digit.
- load_ready, output, 1: block can accept a load.
- load_err, output, 1: one-cycle pulse when the accepted load_time was illegal.
- time_bcd, output, 24: current time, same packing as load_time.
- sec_pulse, output, 1: one-cycle pulse on each seconds increment.
- min_pulse, output, 1: one-cycle pulse when seconds wrap 59->00.
- hour_pulse, output, 1: one-cycle pulse when minutes wrap 59->00.
- day_pulse, output, 1: one-cycle pulse when the time wraps 23:59:59->00:00:00.

Behaviour:
Reset values:
- time_bcd=RESET_TIME; prescaler=0; load_ready=1.
- load_err, sec_pulse, min_pulse, hour_pulse and day_pulse all =0.
- FSM=STOPPED.

FSM states: STOPPED, RUNNING, LOADING.
- STOPPED->RUNNING when run=1 and no load is accepted.
- RUNNING->STOPPED when run=0.
- Any state->LOADING on load_valid&&load_ready. That cycle latches load_time, and load_ready goes 0 the next cycle.
- LOADING lasts exactly one cycle, then returns to RUNNING if run=1, else STOPPED. load_ready returns to 1.

Prescaler:
- Increments on tick only in RUNNING. At TICKS_PER_SEC-1 it clears and generates a seconds increment.
- Clears on an accepted load.
- Holds its value in STOPPED, so a partial second is kept across stop/start.

Increment:
- Ripple-carry through the digits with limits S0 0-9, S1 0-5, M0 0-9, M1 0-5, H0 0-9, H1 0-2. When H1=2, H0 is limited to 0-3.
- All digits update in the same clk as the increment (zero latency from the accepted tick edge). The next cycle shows the new time_bcd.
- Rollover pulses are registered and asserted in the same cycle time_bcd shows the new value.
- Pulses are nested: day_pulse implies hour_pulse implies min_pulse implies sec_pulse.

Load validation (LOADING cycle):
- Legal means every digit is within its limit, including hours <= 23.
- Legal: time_bcd<=latched value.
- Illegal: time_bcd unchanged, load_err=1 for that one cycle.
- No rollover pulses are generated by a load.

Simultaneous events:
- load accept + tick in the same cycle: the load wins and the tick is dropped.
- tick during LOADING: dropped.
- tick while stopped: ignored.
- run toggling in the same cycle as tick: the registered FSM state decides.

Other boundaries:
- rst mid-LOADING: the load is discarded and reset values are applied.
- tick held high for several cycles: counts once per cycle. The upstream divider guarantees single-cycle pulses; this is not protected against.

Optional Feature:
Macro RTC_ALARM_EN.
- Defined: adds input alarm_wr (1), input alarm_time (16, BCD HHMM), input alarm_arm (1), output alarm_pulse (1).
  - alarm_wr latches alarm_time, with the same legality check. An illegal value is ignored and load_err is pulsed.
  - alarm_pulse is a one-cycle pulse when alarm_arm=1 and a min_pulse results in time_bcd[23:8]==alarm register.
  - A load to a matching time does not fire the alarm.
  - Reset: alarm register 00:00, alarm_pulse=0.
- Undefined: these ports and that logic are absent.

Decomposition:
- Package rtc_pkg holds:
  - BCD digit typedef (4 bits) and packed time typedef (24 bits).
  - Digit limit constants: S0_MAX=9, S1_MAX=5, M0_MAX=9, M1_MAX=5, H1_MAX=2, H_MAX_TENS2_UNITS=3.
  - FSM state enum.
  - A legality-check function shared by the load and alarm paths.
- Sub-module: bcd_digit_counter. One digit with parameterisable or input max value, carry_in, clear, carry_out. Instantiated six times; the H0 limit is selected by H1.

Test Plan:
1. rst, run=1, TICKS_PER_SEC=1, 60 ticks -> time_bcd=24'h000100, min_pulse exactly once, on the 60th increment.
2. Load 24'h235959 then one tick -> time_bcd=24'h000000; sec_pulse, min_pulse, hour_pulse and day_pulse all high in the same cycle.
3. Load 24'h246000 -> load_err one cycle, time unchanged. Load 24'h125960 -> load_err. Load 24'h095959 -> accepted, no error.
4. TICKS_PER_SEC=4: 3 ticks, run=0, 5 ticks, run=1, 1 tick -> exactly one seconds increment, time_bcd=000001.
5. load_valid and tick in the same cycle with load_time=24'h120000 -> time_bcd=24'h120000. load_ready is 0 for one cycle, and the tick is lost.
6. RTC_ALARM_EN: alarm 07:30 armed, load 24'h072959, one tick -> alarm_pulse one cycle, time_bcd=24'h073000. Disarmed repeat -> no pulse.
